id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and operand width.
REQ-002 Parameter NUM_FWD, default 2, number of forwarding sources; index 0 is youngest (EX), highest priority.
REQ-003 Parameter CNT_W, default 16, width of stall counter.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake; transfer when both 1.
REQ-007 in_pc / in_inst  in  XLEN / 32  PC and instruction from IF.
REQ-008 reg1_addr_o / reg2_addr_o  out  5 / 5  regfile read addresses = in_inst[19:15] / [24:20], combinational.
REQ-009 reg1_data_i / reg2_data_i  in  XLEN  regfile combinational read data.
REQ-010 fwd_wreg / fwd_load  in  NUM_FWD  per-source write-enable / result-is-load flag.
REQ-011 fwd_wd / fwd_wdata  in  5*NUM_FWD / XLEN*NUM_FWD  per-source dest address / result, source i at slice i.
REQ-012 flush  in  1  discard held and incoming instruction.
REQ-013 out_valid / out_ready  out / in  1 / 1  EX-side handshake.
REQ-014 out_pc, out_reg1, out_reg2, out_imm  out  XLEN each  registered PC, operand 1, operand 2, immediate.
REQ-015 out_aluop / out_alusel  out  4 / 2  ALU op: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 NOP15; sel: NOP0 LOGIC1 SHIFT2 ARITH3.
REQ-016 out_wd / out_wreg / out_illegal  out  5 / 1 / 1  dest register, write enable, illegal-instruction flag.
REQ-017 stall_cnt  out  CNT_W  load-use stall cycle counter.

Function
REQ-018 Decoded opcodes: OP-IMM 0010011, OP 0110011, LUI 0110111; any other opcode, OP with funct7 not 0000000/0100000 (0100000 only for ADD->SUB, SRL->SRA), or shift-imm with inst[31:25] not 0000000/0100000 (0100000 only SRAI) SHALL set out_illegal=1, out_wreg=0, aluop NOP, alusel NOP.
REQ-019 OP-IMM: reads rs1 only; imm = sign-extended inst[31:20]; shifts use imm = zero-extended inst[24:20]; out_reg2 = imm.
REQ-020 OP: reads rs1 and rs2; out_imm = 0.
REQ-021 LUI: reads nothing; out_reg1 = 0; out_imm = out_reg2 = {inst[31:12],12'h0}; aluop ADD, alusel ARITH.
REQ-022 Logic ops -> LOGIC; shifts -> SHIFT; ADD/SUB/SLT/SLTU -> ARITH.
REQ-023 out_wreg = 1 for legal instruction with rd != 0; out_wd = inst[11:7] always.
REQ-024 Operand source for a read register r: lowest index i with fwd_wreg[i]=1, fwd_wd[i]=r, r!=0 supplies fwd_wdata[i]; else regfile data; r=0 always yields 0.
REQ-025 Load-use hazard: selected source per REQ-024 has fwd_load[i]=1 for any read operand; hazard forces in_ready=0.
REQ-026 in_ready = (!out_valid | out_ready) & !hazard & !flush, combinational.
REQ-027 On transfer, decoded fields register on the next rising edge and out_valid=1 (latency 1 cycle).
REQ-028 out_valid & out_ready with no transfer: out_valid=0 next cycle; out_valid & !out_ready: all outputs held stable.
REQ-029 flush=1: out_valid=0 next cycle regardless of other inputs; incoming instruction not accepted.
REQ-030 stall_cnt increments by 1 each cycle in_valid & hazard & !flush; saturates at all-ones, no wrap.
REQ-031 Outputs other than reg addresses change only at clock edges.

Reset
REQ-032 rst=0 asynchronously clears out_valid, out_pc, out_reg1, out_reg2, out_imm, out_wd, out_wreg, out_illegal, stall_cnt to 0, out_aluop to 15, out_alusel to 0.
REQ-033 Reset mid-stall or mid-handshake discards held instruction; first transfer possible on first edge after rst returns to 1.

Verification
REQ-034 ADDI x5,x1,-1 (0xFFF08293), x1=7 regfile, no fwd -> out_reg1=7, out_imm=out_reg2=0xFFFFFFFF, aluop 0, alusel 3, wd 5, wreg 1, one cycle later.
REQ-035 ADD x3,x1,x2; fwd0 wd=1 data=0xA, fwd1 wd=1 data=0xB, fwd1 wd=2 data=0xC in separate test -> out_reg1=0xA (source 0 wins), out_reg2=0xC.
REQ-036 fwd0 wd=1 load=1, inst reads x1 -> in_ready=0, stall_cnt +1 per cycle for 3 cycles; drop fwd_load -> transfer, stall_cnt=3.
REQ-037 out_ready=0 for 4 cycles with valid output -> outputs stable, in_ready=0; flush=1 -> out_valid=0 next cycle.
REQ-038 inst 0x00000000 -> out_illegal=1, wreg 0; ADD x0,x1,x2 -> wreg 0; fwd wd=0 data=0x55 with rs1=x0 -> out_reg1=0.
REQ-039 Assert rst=0 asynchronously between edges during stall -> outputs at reset values immediately, stall_cnt=0.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage for an RV32I subset (OP-IMM, OP, LUI) with priority operand forwarding,
// load-use stall detection and a single registered valid/ready output slot.
module id_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg,
  input  logic [NUM_FWD-1:0]      fwd_load,
  input  logic [5*NUM_FWD-1:0]    fwd_wd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_reg1,
  output logic [XLEN-1:0]         out_reg2,
  output logic [XLEN-1:0]         out_imm,
  output logic [3:0]              out_aluop,
  output logic [1:0]              out_alusel,
  output logic [4:0]              out_wd,
  output logic                    out_wreg,
  output logic                    out_illegal,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [1:0] SEL_NOP   = 2'd0;
  localparam logic [1:0] SEL_LOGIC = 2'd1;
  localparam logic [1:0] SEL_SHIFT = 2'd2;
  localparam logic [1:0] SEL_ARITH = 2'd3;

  // funct3 -> ALU op for the funct7 == 0 encodings shared by OP and OP-IMM
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            illegal_c, use1_c, use2_c, ld1_c, ld2_c, hazard_c, transfer_c;
  logic [3:0]      aluop_c;
  logic [1:0]      alusel_c;
  logic [XLEN-1:0] imm_c, op1_c, op2_c;

  logic            valid_q, valid_d, wreg_q, wreg_d, illegal_q, illegal_d;
  logic [XLEN-1:0] pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
  logic [3:0]      aluop_q, aluop_d;
  logic [1:0]      alusel_q, alusel_d;
  logic [4:0]      wd_q, wd_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign opcode      = in_inst[6:0];
  assign funct3      = in_inst[14:12];
  assign funct7      = in_inst[31:25];
  assign reg1_addr_o = in_inst[19:15];
  assign reg2_addr_o = in_inst[24:20];

  // Instruction decode; anything not recognised collapses to an illegal NOP
  always_comb begin
    illegal_c = 1'b1;
    aluop_c   = ALU_NOP;
    imm_c     = '0;
    use1_c    = 1'b0;
    use2_c    = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        illegal_c = 1'b0;
        use1_c    = 1'b1;
        aluop_c   = base_op(funct3);
        imm_c     = XLEN'($signed(in_inst[31:20]));
        if (funct3[1:0] == 2'b01) begin
          imm_c = XLEN'(in_inst[24:20]);
          if (funct3[2] && (funct7 == F7_ALT)) aluop_c = ALU_SRA;
          else if (funct7 != F7_ZERO)          illegal_c = 1'b1;
        end
      end
      OPC_OP: begin
        illegal_c = 1'b0;
        use1_c    = 1'b1;
        use2_c    = 1'b1;
        aluop_c   = base_op(funct3);
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      aluop_c = ALU_SUB;
          else if (funct3 == 3'b101) aluop_c = ALU_SRA;
          else                       illegal_c = 1'b1;
        end else if (funct7 != F7_ZERO) begin
          illegal_c = 1'b1;
        end
      end
      OPC_LUI: begin
        illegal_c = 1'b0;
        aluop_c   = ALU_ADD;
        imm_c     = XLEN'($signed({in_inst[31:12], 12'h000}));
      end
      default: ;
    endcase
    if (illegal_c) begin
      aluop_c = ALU_NOP;
      imm_c   = '0;
      use1_c  = 1'b0;
      use2_c  = 1'b0;
    end
  end

  always_comb begin
    case (aluop_c)
      ALU_XOR, ALU_OR, ALU_AND:             alusel_c = SEL_LOGIC;
      ALU_SLL, ALU_SRL, ALU_SRA:            alusel_c = SEL_SHIFT;
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU:  alusel_c = SEL_ARITH;
      default:                              alusel_c = SEL_NOP;
    endcase
  end

  // Walk sources oldest to youngest so the lowest index is applied last and wins
  always_comb begin
    op1_c = reg1_data_i;
    op2_c = reg2_data_i;
    ld1_c = 1'b0;
    ld2_c = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_wreg[i] && (fwd_wd[5*i +: 5] == reg1_addr_o)) begin
        op1_c = fwd_wdata[XLEN*i +: XLEN];
        ld1_c = fwd_load[i];
      end
      if (fwd_wreg[i] && (fwd_wd[5*i +: 5] == reg2_addr_o)) begin
        op2_c = fwd_wdata[XLEN*i +: XLEN];
        ld2_c = fwd_load[i];
      end
    end
    if (reg1_addr_o == 5'd0) begin
      op1_c = '0;
      ld1_c = 1'b0;
    end
    if (reg2_addr_o == 5'd0) begin
      op2_c = '0;
      ld2_c = 1'b0;
    end
  end

  assign hazard_c   = (use1_c & ld1_c) | (use2_c & ld2_c);
  assign in_ready   = (~valid_q | out_ready) & ~hazard_c & ~flush;
  assign transfer_c = in_valid & in_ready;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    imm_d     = imm_q;
    aluop_d   = aluop_q;
    alusel_d  = alusel_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    illegal_d = illegal_q;
    stall_d   = stall_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (transfer_c) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      reg1_d    = use1_c ? op1_c : '0;
      reg2_d    = use2_c ? op2_c : imm_c;
      imm_d     = imm_c;
      aluop_d   = aluop_c;
      alusel_d  = alusel_c;
      wd_d      = in_inst[11:7];
      wreg_d    = ~illegal_c & (in_inst[11:7] != 5'd0);
      illegal_d = illegal_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && hazard_c && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      imm_q     <= '0;
      aluop_q   <= ALU_NOP;
      alusel_q  <= SEL_NOP;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      imm_q     <= imm_d;
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_reg1    = reg1_q;
  assign out_reg2    = reg2_q;
  assign out_imm     = imm_q;
  assign out_aluop   = aluop_q;
  assign out_alusel  = alusel_q;
  assign out_wd      = wd_q;
  assign out_wreg    = wreg_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus a randomized run scored against
// an instruction-level reference model (CNT_W shrunk to 4 to reach saturation).
module tb_id_stage;

  localparam int CW = 4;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, reg1_data_i, reg2_data_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [1:0]  fwd_wreg, fwd_load;
  logic [9:0]  fwd_wd;
  logic [63:0] fwd_wdata;
  logic [31:0] out_pc, out_reg1, out_reg2, out_imm;
  logic [3:0]  out_aluop;
  logic [1:0]  out_alusel;
  logic [4:0]  out_wd;
  logic        out_wreg, out_illegal;
  logic [CW-1:0] stall_cnt;

  logic [31:0] rf [32];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc, r1, r2, imm;
    logic [3:0]  aluop;
    logic [1:0]  alusel;
    logic [4:0]  wd;
    logic        wreg, illegal;
  } exp_t;

  id_stage #(.XLEN(32), .NUM_FWD(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg(fwd_wreg), .fwd_load(fwd_load), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_wd(out_wd),
    .out_wreg(out_wreg), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  // Operand fields carry no meaning for an illegal instruction
  function automatic exp_t mask(input exp_t x);
    exp_t m = x;
    if (m.illegal) begin
      m.r1 = '0; m.r2 = '0; m.imm = '0;
    end
    return m;
  endfunction

  function automatic exp_t cur();
    exp_t g;
    g.pc = out_pc; g.r1 = out_reg1; g.r2 = out_reg2; g.imm = out_imm;
    g.aluop = out_aluop; g.alusel = out_alusel; g.wd = out_wd;
    g.wreg = out_wreg; g.illegal = out_illegal;
    return mask(g);
  endfunction

  function automatic exp_t rst_exp();
    exp_t e = '0;
    e.aluop = 4'd15;
    return e;
  endfunction

  // Value of register r as seen by the stage: youngest matching forward, else regfile
  function automatic logic [31:0] operand(input logic [4:0] r, output logic ld);
    ld = 1'b0;
    if (r == 5'd0) return 32'h0;
    for (int i = 0; i < 2; i++) begin
      if (fwd_wreg[i] && fwd_wd[5*i +: 5] == r) begin
        ld = fwd_load[i];
        return fwd_wdata[32*i +: 32];
      end
    end
    return rf[r];
  endfunction

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'd0;  3'd1: return 4'd2;  3'd2: return 4'd3;  3'd3: return 4'd4;
      3'd4: return 4'd5;  3'd5: return 4'd6;  3'd6: return 4'd8;  default: return 4'd9;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst, output logic hz);
    exp_t e;
    logic [6:0] opc = inst[6:0];
    logic [6:0] f7  = inst[31:25];
    logic [2:0] f3  = inst[14:12];
    logic ok = 1'b0, u1 = 1'b0, u2 = 1'b0, l1 = 1'b0, l2 = 1'b0;
    logic [3:0]  op = 4'd15;
    logic [31:0] imm = 32'h0;
    e = '0; e.pc = pc; e.wd = inst[11:7]; e.aluop = 4'd15; e.illegal = 1'b1; hz = 1'b0;
    if (opc == 7'h13) begin
      u1 = 1'b1; op = f3_op(f3);
      if (f3 == 3'd1 || f3 == 3'd5) begin
        imm = {27'h0, inst[24:20]};
        ok  = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        if (f7 == 7'h20) op = 4'd7;
      end else begin
        imm = {{20{inst[31]}}, inst[31:20]};
        ok  = 1'b1;
      end
    end else if (opc == 7'h33) begin
      u1 = 1'b1; u2 = 1'b1; op = f3_op(f3);
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (f7 == 7'h20) op = (f3 == 3'd0) ? 4'd1 : 4'd7;
    end else if (opc == 7'h37) begin
      op = 4'd0; imm = {inst[31:12], 12'h000}; ok = 1'b1;
    end
    if (ok) begin
      e.illegal = 1'b0;
      e.aluop   = op;
      e.alusel  = (op == 4'd5 || op == 4'd8 || op == 4'd9) ? 2'd1 :
                  (op == 4'd2 || op == 4'd6 || op == 4'd7) ? 2'd2 : 2'd3;
      e.wreg    = (inst[11:7] != 5'd0);
      e.imm     = imm;
      e.r1      = u1 ? operand(inst[19:15], l1) : 32'h0;
      e.r2      = u2 ? operand(inst[24:20], l2) : imm;
      hz        = (u1 & l1) | (u2 & l2);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    logic [6:0]  f7;
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [4:0]  rs1 = 5'($urandom_range(0, 7));
    logic [4:0]  rs2 = 5'($urandom_range(0, 7));
    logic [2:0]  f3  = r[14:12];
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 9))
      0, 1, 2: return {f7, rs2, rs1, f3, rd, 7'h13};
      3:       return {r[31:20], rs1, f3, rd, 7'h13};
      4, 5, 6: return {f7, rs2, rs1, f3, rd, 7'h33};
      7:       return {r[31:12], rd, 7'h37};
      8:       return r;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fwd_wreg = '0; fwd_load = '0; fwd_wd = '0; fwd_wdata = '0;
    in_inst = 32'h0; in_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_inst = inst; in_pc = pc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #12;
    n_tests++;
    if (cur() !== rst_exp() || out_valid !== 1'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_values got=%h v=%b st=%0d exp=%h v=0 st=0", cur(), out_valid, stall_cnt, rst_exp());
    end
    do_reset();
  endtask

  task automatic test_addi();
    do_reset();
    rf[1] = 32'd7;
    in_inst = 32'hFFF08293; in_pc = 32'h100; in_valid = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || reg1_addr_o !== 5'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL addi_pre got rdy=%b a1=%0d v=%b exp rdy=1 a1=1 v=0", in_ready, reg1_addr_o, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_reg1 !== 32'd7 || out_imm !== 32'hFFFFFFFF || out_reg2 !== 32'hFFFFFFFF ||
        out_aluop !== 4'd0 || out_alusel !== 2'd3 || out_wd !== 5'd5 || out_wreg !== 1'b1 || out_pc !== 32'h100) begin
      n_fail++; $display("FAIL addi_fields got v=%b fields=%h exp v=1 r1=7 r2=imm=ffffffff op=0 sel=3 wd=5 wreg=1", out_valid, cur());
    end
  endtask

  task automatic test_forward();
    do_reset();
    rf[1] = 32'h11; rf[2] = 32'h22;
    fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'hB, 32'hA};
    issue(32'h002081B3, 32'h200);
    n_tests++;
    if (out_reg1 !== 32'hA || out_reg2 !== 32'h22) begin
      n_fail++; $display("FAIL fwd_priority got r1=%h r2=%h exp r1=a r2=22", out_reg1, out_reg2);
    end
    fwd_wd = {5'd2, 5'd1}; fwd_wdata = {32'hC, 32'hA};
    issue(32'h002081B3, 32'h204);
    n_tests++;
    if (out_reg1 !== 32'hA || out_reg2 !== 32'hC || out_wreg !== 1'b1 || out_wd !== 5'd3) begin
      n_fail++; $display("FAIL fwd_src1 got r1=%h r2=%h wreg=%b wd=%0d exp r1=a r2=c wreg=1 wd=3", out_reg1, out_reg2, out_wreg, out_wd);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    fwd_wreg = 2'b01; fwd_load = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_wdata = {32'h0, 32'hA};
    in_inst = 32'h002081B3; in_pc = 32'h300; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL loaduse_ready cyc %0d got=%b exp=0", k, in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (stall_cnt !== CW'(k) || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL loaduse_cnt cyc %0d got st=%0d v=%b exp st=%0d v=0", k, stall_cnt, out_valid, k);
      end
    end
    fwd_load = 2'b00;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_reg1 !== 32'hA || stall_cnt !== CW'(3)) begin
      n_fail++; $display("FAIL loaduse_release got v=%b r1=%h st=%0d exp v=1 r1=a st=3", out_valid, out_reg1, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    fwd_wreg = 2'b10; fwd_load = 2'b10; fwd_wd = {5'd1, 5'd0};
    in_inst = 32'h00108093; in_valid = 1'b1; flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL stall_flush got=%0d exp=0", stall_cnt);
    end
    flush = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt !== CW'(15)) begin
      n_fail++; $display("FAIL stall_saturate got=%0d exp=15", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure_flush();
    exp_t e1;
    logic hz;
    do_reset();
    out_ready = 1'b0;
    in_inst = 32'hFFF08293; in_pc = 32'h400;
    e1 = model(in_pc, in_inst, hz);
    issue(32'hFFF08293, 32'h400);
    in_inst = 32'h002081B3; in_pc = 32'h404; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready cyc %0d got=%b exp=0", k, in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || cur() !== mask(e1)) begin
        n_fail++; $display("FAIL hold_stable cyc %0d got v=%b %h exp v=1 %h", k, out_valid, cur(), mask(e1));
      end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid);
    end
    clear_inputs();
  endtask

  task automatic test_x0_illegal();
    do_reset();
    issue(32'h00000000, 32'h500);
    n_tests++;
    if (out_illegal !== 1'b1 || out_wreg !== 1'b0 || out_aluop !== 4'd15 || out_alusel !== 2'd0) begin
      n_fail++; $display("FAIL illegal_zero got ill=%b wreg=%b op=%0d sel=%0d exp 1 0 15 0", out_illegal, out_wreg, out_aluop, out_alusel);
    end
    issue(32'h00208033, 32'h504);
    n_tests++;
    if (out_wreg !== 1'b0 || out_illegal !== 1'b0 || out_wd !== 5'd0) begin
      n_fail++; $display("FAIL add_x0 got wreg=%b ill=%b wd=%0d exp 0 0 0", out_wreg, out_illegal, out_wd);
    end
    rf[0] = 32'hDEAD;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'h55};
    issue(32'h00100293, 32'h508);
    n_tests++;
    if (out_reg1 !== 32'h0 || out_reg2 !== 32'h1) begin
      n_fail++; $display("FAIL x0_operand got r1=%h r2=%h exp r1=0 r2=1", out_reg1, out_reg2);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic hz;
    do_reset();
    out_ready = 1'b0;
    issue(32'hFFF08293, 32'h600);
    fwd_wreg = 2'b01; fwd_load = 2'b01; fwd_wd = {5'd0, 5'd1};
    in_inst = 32'h002081B3; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt !== CW'(2) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_async got st=%0d v=%b exp st=2 v=1", stall_cnt, out_valid);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (cur() !== rst_exp() || out_valid !== 1'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL async_reset got=%h v=%b st=%0d exp=%h v=0 st=0", cur(), out_valid, stall_cnt, rst_exp());
    end
    #1 rst = 1'b1;
    fwd_load = 2'b00; fwd_wreg = 2'b00; out_ready = 1'b1;
    in_inst = 32'hFFF08293; in_pc = 32'h610;
    e = model(in_pc, in_inst, hz);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || cur() !== mask(e)) begin
      n_fail++; $display("FAIL post_reset_xfer got v=%b %h exp v=1 %h", out_valid, cur(), mask(e));
    end
    clear_inputs();
  endtask

  // Randomized handshake/decode run against a transaction-level expectation
  task automatic test_random();
    exp_t e, held;
    logic hz, ev, er;
    int st;
    do_reset();
    ev = 1'b0; st = 0; held = '0;
    for (int n = 0; n < 300; n++) begin
      in_inst   = rand_inst();
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      fwd_wreg  = 2'($urandom_range(0, 3));
      fwd_wd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_wdata = {$urandom, $urandom};
      fwd_load  = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      rf[$urandom_range(0, 7)] = $urandom;
      #1;
      e  = model(in_pc, in_inst, hz);
      er = (!ev || out_ready) && !hz && !flush;
      n_tests++;
      if (in_ready !== er || reg1_addr_o !== in_inst[19:15] || reg2_addr_o !== in_inst[24:20]) begin
        n_fail++; $display("FAIL rand_ready it %0d got rdy=%b a=%0d/%0d exp rdy=%b a=%0d/%0d", n, in_ready,
                           reg1_addr_o, reg2_addr_o, er, in_inst[19:15], in_inst[24:20]);
      end
      @(posedge clk);
      if (in_valid && hz && !flush && st < 15) st++;
      if (flush) ev = 1'b0;
      else if (in_valid && er) begin ev = 1'b1; held = e; end
      else if (out_ready) ev = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== ev || (ev && cur() !== mask(held)) || stall_cnt !== CW'(st)) begin
        n_fail++; $display("FAIL rand_out it %0d got v=%b %h st=%0d exp v=%b %h st=%0d", n, out_valid, cur(),
                           stall_cnt, ev, mask(held), st);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_saturate();
    test_backpressure_flush();
    test_x0_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
